// File: rtl/axis_conv3x3_stream.sv
// AXI4-Stream 3x3 signed convolution with two line buffers, rounding and
// selectable saturate / absolute-value output; config is latched at start of frame.
module axis_conv3x3_stream #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned COEF_WIDTH = 8,
    parameter int unsigned FRAC_BITS  = 0,
    parameter int unsigned MAX_WIDTH  = 1920,
    parameter int unsigned WIDTH_BITS = 11
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    input  logic                  cfg_we,
    input  logic [3:0]            cfg_addr,
    input  logic [WIDTH_BITS-1:0] cfg_wdata,
    output logic                  err_line
);

    localparam int unsigned PROD_W = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int unsigned SUM_W  = PROD_W + 4;
    localparam int unsigned RND    = (1 << FRAC_BITS) >> 1;
    localparam logic signed [SUM_W-1:0]      RND_S     = SUM_W'(RND);
    localparam logic signed [SUM_W-1:0]      PIX_MAX   = SUM_W'((1 << DATA_WIDTH) - 1);
    localparam logic signed [COEF_WIDTH-1:0] COEF_ONE  = COEF_WIDTH'(1 << FRAC_BITS);
    localparam logic [WIDTH_BITS-1:0]        WIDTH_MAX = WIDTH_BITS'(MAX_WIDTH);

    logic signed [COEF_WIDTH-1:0] coef_sh  [9];
    logic signed [COEF_WIDTH-1:0] coef_act [9];
    logic signed [COEF_WIDTH-1:0] coef_eff [9];
    logic [WIDTH_BITS-1:0] width_sh, width_act, width_eff;
    logic                  mode_sh, mode_act, mode_eff;

    logic [WIDTH_BITS-1:0] col_q, col_cur;
    logic [1:0]            row_q, row_cur;
    logic                  frame_active_q, frame_live;
    logic                  in_acc, sof, last_col, produce;

    logic [DATA_WIDTH-1:0] lb0 [MAX_WIDTH];
    logic [DATA_WIDTH-1:0] lb1 [MAX_WIDTH];
    logic [DATA_WIDTH-1:0] win [3][2];
    logic [DATA_WIDTH-1:0] newcol [3];
    logic [DATA_WIDTH-1:0] tap [9];

    logic signed [PROD_W-1:0] prod [9];
    logic signed [SUM_W-1:0]  sum, rnd_sum, shifted, mag;
    logic [DATA_WIDTH-1:0]    pix_out;

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign in_acc        = s_axis_tvalid && s_axis_tready;
    assign sof           = in_acc && s_axis_tuser;

    // The SOF pixel itself must see the freshly copied shadow set.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            coef_eff[i] = sof ? coef_sh[i] : coef_act[i];
        end
        width_eff = sof ? width_sh : width_act;
        mode_eff  = sof ? mode_sh : mode_act;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 9; i++) begin
                coef_sh[i]  <= (i == 4) ? COEF_ONE : '0;
                coef_act[i] <= (i == 4) ? COEF_ONE : '0;
            end
            width_sh  <= WIDTH_MAX;
            width_act <= WIDTH_MAX;
            mode_sh   <= 1'b0;
            mode_act  <= 1'b0;
        end else begin
            if (cfg_we) begin
                if (cfg_addr < 4'd9) begin
                    coef_sh[cfg_addr] <= $signed(cfg_wdata[COEF_WIDTH-1:0]);
                end else if (cfg_addr == 4'd9) begin
                    if (cfg_wdata >= WIDTH_BITS'(3) && cfg_wdata <= WIDTH_MAX) begin
                        width_sh <= cfg_wdata;
                    end
                end else if (cfg_addr == 4'd10) begin
                    mode_sh <= cfg_wdata[0];
                end
            end
            if (sof) begin
                coef_act  <= coef_sh;
                width_act <= width_sh;
                mode_act  <= mode_sh;
            end
        end
    end

    always_comb begin
        col_cur    = s_axis_tuser ? '0 : col_q;
        row_cur    = s_axis_tuser ? '0 : row_q;
        frame_live = frame_active_q || s_axis_tuser;
        last_col   = (col_cur == width_eff - WIDTH_BITS'(1));
        produce    = in_acc && frame_live && row_cur[1] && (col_cur >= WIDTH_BITS'(2));
    end

    // row_q saturates at 3 so that "row == 2" still identifies the first output row.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            col_q          <= '0;
            row_q          <= '0;
            frame_active_q <= 1'b0;
            err_line       <= 1'b0;
        end else if (in_acc && frame_live) begin
            col_q          <= last_col ? '0 : col_cur + WIDTH_BITS'(1);
            row_q          <= (last_col && row_cur != 2'd3) ? row_cur + 2'd1 : row_cur;
            frame_active_q <= 1'b1;
            if (s_axis_tlast != last_col) begin
                err_line <= 1'b1;
            end
        end
    end

    always_comb begin
        newcol[0] = lb1[col_cur];
        newcol[1] = lb0[col_cur];
        newcol[2] = s_axis_tdata;
        for (int r = 0; r < 3; r++) begin
            tap[r*3+0] = win[r][0];
            tap[r*3+1] = win[r][1];
            tap[r*3+2] = newcol[r];
        end
    end

    always_ff @(posedge ACLK) begin
        if (in_acc) begin
            lb1[col_cur] <= lb0[col_cur];
            lb0[col_cur] <= s_axis_tdata;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= newcol[r];
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < 9; i++) begin
            prod[i] = PROD_W'($signed({1'b0, tap[i]})) * PROD_W'(coef_eff[i]);
            sum     = sum + SUM_W'(prod[i]);
        end
        rnd_sum = sum + RND_S;
        shifted = rnd_sum >>> FRAC_BITS;
        mag     = (mode_eff && shifted < 0) ? -shifted : shifted;
        if (mag < 0) begin
            pix_out = '0;
        end else if (mag > PIX_MAX) begin
            pix_out = '1;
        end else begin
            pix_out = mag[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (in_acc) begin
            m_axis_tvalid <= produce;
            if (produce) begin
                m_axis_tdata <= pix_out;
                m_axis_tuser <= (row_cur == 2'd2) && (col_cur == WIDTH_BITS'(2));
                m_axis_tlast <= last_col;
            end
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_conv3x3_stream.sv
// Bench for axis_conv3x3_stream: a FRAC_BITS=0 and a FRAC_BITS=2 instance share the
// input stream; a reference model fills scoreboard queues that output monitors drain.
module tb_axis_conv3x3_stream;

    localparam int WB = 11;

    logic       ACLK = 1'b0;
    logic       ARESETN = 1'b0;
    logic [7:0] s_tdata = '0;
    logic       s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
    logic       s_tready0, s_tready1;
    logic [7:0] m_tdata0, m_tdata1;
    logic       m_tvalid0, m_tvalid1, m_tuser0, m_tuser1, m_tlast0, m_tlast1;
    logic       m_tready = 1'b1;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [WB-1:0] cfg_wdata = '0;
    logic       err0, err1;

    always #5 ACLK = ~ACLK;

    axis_conv3x3_stream dut0 (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready0),
        .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready),
        .m_axis_tuser(m_tuser0), .m_axis_tlast(m_tlast0),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .err_line(err0)
    );

    axis_conv3x3_stream #(.FRAC_BITS(2)) dut1 (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready1),
        .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready),
        .m_axis_tuser(m_tuser1), .m_axis_tlast(m_tlast1),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .err_line(err1)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       user;
        logic       last;
    } exp_t;

    typedef struct packed {
        logic [8:0][7:0] k;
        logic            wr_k;
        logic            mode;
        logic [3:0]      w;
        logic [3:0]      h;
        logic [2:0]      kind;
        logic            bp;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   failures = 0;
    int   img[8][8];
    int   mk0[9];
    int   mk1[9];
    int   mm = 0;
    bit   bp_en = 1'b0;
    bit   held_v[2];
    exp_t held[2];
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [8:0][7:0] kern(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        logic [8:0][7:0] k;
        k[0] = 8'(a0); k[1] = 8'(a1); k[2] = 8'(a2);
        k[3] = 8'(a3); k[4] = 8'(a4); k[5] = 8'(a5);
        k[6] = 8'(a6); k[7] = 8'(a7); k[8] = 8'(a8);
        return k;
    endfunction

    function automatic vec_t mkvec(input logic [8:0][7:0] k, input bit wr_k, input bit mode,
                                   input int w, input int h, input int kind, input bit bp);
        vec_t v;
        v.k = k; v.wr_k = wr_k; v.mode = mode; v.w = 4'(w); v.h = 4'(h);
        v.kind = 3'(kind); v.bp = bp;
        return v;
    endfunction

    function automatic int pix(input int kind, input int x, input int y);
        case (kind)
            0: return 16 * y + x;
            1: return 10 * x;
            2: return 255;
            3: return 3;
            default: return (x * 37 + y * 91 + 13) & 255;
        endcase
    endfunction

    function automatic exp_t ref_out(input int x, input int y, input int w, input int k[9],
                                     input int fb);
        int   s;
        exp_t e;
        s = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                s += k[r*3+c] * img[y-2+r][x-2+c];
            end
        end
        if (fb > 0) s = (s + (1 << (fb - 1))) >>> fb;
        if (mm != 0 && s < 0) s = -s;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        e.data = s[7:0];
        e.user = (x == 2 && y == 2);
        e.last = (x == w - 1);
        return e;
    endfunction

    task automatic mon(input int i, input logic v, input logic [7:0] d, input logic u,
                       input logic l);
        exp_t got;
        exp_t e;
        bit   empty;
        got = {d, u, l};
        if (held_v[i]) check($sformatf("stall_hold%0d", i), int'({v, got}), int'({1'b1, held[i]}));
        held_v[i] = v && !m_tready;
        held[i] = got;
        if (v && m_tready) begin
            empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out%0d actual=%0h required=none", i, got);
            end else begin
                if (i == 0) e = q0.pop_front();
                else e = q1.pop_front();
                check($sformatf("out%0d", i), int'(got), int'(e));
            end
        end
    endtask

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            held_v[0] = 1'b0;
            held_v[1] = 1'b0;
        end else begin
            mon(0, m_tvalid0, m_tdata0, m_tuser0, m_tlast0);
            mon(1, m_tvalid1, m_tdata1, m_tuser1, m_tlast1);
        end
    end

    initial begin
        forever begin
            @(posedge ACLK);
            #1;
            if (bp_en) m_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cfg_write(input int a, input int d);
        cfg_we = 1'b1;
        cfg_addr = 4'(a);
        cfg_wdata = WB'(d);
        @(posedge ACLK);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic send_pixel(input int d, input bit u, input bit l);
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        s_tdata = 8'(d); s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge ACLK);
            ok = s_tready0;
            @(posedge ACLK);
            #1;
            n++;
        end
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL input_accept actual=stalled required=accepted");
        end
    endtask

    task automatic send_frame(input int w, input int h, input int kind, input bit bad,
                              input bit midcfg);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) img[y][x] = pix(kind, x, y);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (y >= 2 && x >= 2) begin
                    q0.push_back(ref_out(x, y, w, mk0, 0));
                    q1.push_back(ref_out(x, y, w, mk1, 2));
                end
                send_pixel(img[y][x], (x == 0 && y == 0), (x == w - 1) || (bad && y == 0 && x == 2));
                if (midcfg && y == 1 && x == 1) cfg_write(4, 2);
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 2000) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        check({name, "_drained"}, q0.size() + q1.size(), 0);
        repeat (3) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic set_defaults();
        for (int i = 0; i < 9; i++) begin
            mk0[i] = 0;
            mk1[i] = 0;
        end
        mk0[4] = 1;
        mk1[4] = 4;
        mm = 0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        if (v.wr_k) begin
            for (int i = 0; i < 9; i++) begin
                cfg_write(i, int'(v.k[i]));
                mk0[i] = int'($signed(v.k[i]));
                mk1[i] = mk0[i];
            end
        end
        cfg_write(9, int'(v.w));
        cfg_write(10, int'(v.mode));
        mm = int'(v.mode);
        bp_en = v.bp;
        send_frame(int'(v.w), int'(v.h), int'(v.kind), 1'b0, 1'b0);
        wait_drain($sformatf("vec%0d", idx));
        bp_en = 1'b0;
        m_tready = 1'b1;
    endtask

    initial begin
        set_defaults();
        #12;
        check("rst_tvalid0", int'(m_tvalid0), 0);
        check("rst_tdata0", int'(m_tdata0), 0);
        check("rst_tuser0", int'(m_tuser0), 0);
        check("rst_tlast0", int'(m_tlast0), 0);
        check("rst_err0", int'(err0), 0);
        check("rst_tvalid1", int'(m_tvalid1), 0);
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;

        vecs[0] = mkvec(kern(0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b0, 1'b0, 4, 4, 0, 1'b0);
        vecs[1] = mkvec(kern(-1, 0, 1, -2, 0, 2, -1, 0, 1), 1'b1, 1'b1, 8, 4, 1, 1'b0);
        vecs[2] = mkvec(kern(1, 0, -1, 2, 0, -2, 1, 0, -1), 1'b1, 1'b0, 8, 4, 1, 1'b0);
        vecs[3] = mkvec(kern(1, 1, 1, 1, 1, 1, 1, 1, 1), 1'b1, 1'b0, 4, 3, 2, 1'b0);
        vecs[4] = mkvec(kern(1, 1, 1, 1, 1, 1, 1, 1, 1), 1'b1, 1'b0, 4, 3, 3, 1'b0);
        vecs[5] = mkvec(kern(1, -2, 3, 0, 5, -1, 2, 1, -3), 1'b1, 1'b1, 8, 5, 4, 1'b1);
        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Line-length error: stray tlast at column 2 of width-4 lines.
        cfg_write(9, 4);
        cfg_write(10, 0);
        mm = 0;
        for (int i = 0; i < 9; i++) begin
            cfg_write(i, (i == 4) ? 1 : 0);
            mk0[i] = (i == 4) ? 1 : 0;
            mk1[i] = mk0[i];
        end
        check("err_before", int'(err0), 0);
        send_frame(4, 3, 0, 1'b1, 1'b0);
        wait_drain("err_frame");
        check("err_set0", int'(err0), 1);
        check("err_set1", int'(err1), 1);
        send_frame(4, 3, 0, 1'b0, 1'b0);
        wait_drain("err_after");
        check("err_sticky", int'(err0), 1);

        // Mid-frame coef4 write only takes effect from the next frame.
        send_frame(4, 4, 0, 1'b0, 1'b1);
        mk0[4] = 2;
        mk1[4] = 2;
        send_frame(4, 4, 5, 1'b0, 1'b0);
        wait_drain("cfg_timing");

        // Reset while an output is stalled.
        cfg_write(4, 3);
        m_tready = 1'b0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                if (y < 2 || x <= 2) send_pixel(pix(0, x, y), (x == 0 && y == 0), (x == 3));
        check("pending_valid", int'(m_tvalid0), 1);
        ARESETN = 1'b0;
        #1;
        check("rst_mid_valid0", int'(m_tvalid0), 0);
        check("rst_mid_valid1", int'(m_tvalid1), 0);
        check("rst_mid_err", int'(err0), 0);
        q0.delete();
        q1.delete();
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        m_tready = 1'b1;
        set_defaults();
        for (int i = 0; i < 12; i++) send_pixel(pix(0, i % 4, i / 4), 1'b0, (i % 4 == 3));
        repeat (3) begin
            @(posedge ACLK);
            #1;
        end
        cfg_write(9, 4);
        send_frame(4, 4, 0, 1'b0, 1'b0);
        wait_drain("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_conv3x3_stream.md
Name: axis_conv3x3_stream

Overview:
- Parametrised AXI4-Stream 3x3 fixed-point convolution core. It is the successor to the fixed 3x3 convolution IP and sits between the VDMA MM2S stream and the HDMI output path.
- It buffers two lines on-chip and forms a sliding 3x3 window. It applies a runtime-programmable signed kernel with rounding, and offers two selectable output modes: signed-saturate or absolute-value.
- Kernel, line width and mode are loaded through a simple register write port and take effect only at start of frame.

Parameters:
- DATA_WIDTH, 8, unsigned pixel width on both streams.
- COEF_WIDTH, 8, signed two's-complement coefficient width.
- FRAC_BITS, 0, fractional bits of the coefficients; the sum is shifted right by this amount after rounding.
- MAX_WIDTH, 1920, maximum line length in pixels; sets line-buffer depth.
- WIDTH_BITS, 11, width of the line-length and column counters; must satisfy 2^WIDTH_BITS > MAX_WIDTH.

Ports:
- ACLK  in  1  clock, all logic rising-edge.
- ARESETN  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH  input pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tuser  in  1  start of frame, set on pixel (0,0).
- s_axis_tlast  in  1  end of line; used only for the error check.
- m_axis_tdata  out  DATA_WIDTH  output pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tuser  out  1  first output pixel of frame.
- m_axis_tlast  out  1  last output pixel of line.
- cfg_we  in  1  register write strobe.
- cfg_addr  in  4  register address.
- cfg_wdata  in  WIDTH_BITS  write data; low COEF_WIDTH bits are used for coefficients.
- err_line  out  1  sticky line-length error.

Behaviour:
- Clocking and reset: one clock. ARESETN is asynchronous and active-low; deassertion is synchronous to ACLK.
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, err_line=0.
  - Column and row counters = 0; frame_active = 0.
  - Shadow and active registers load the identity kernel: coef4 = 1<<FRAC_BITS, all other coefs 0, width = MAX_WIDTH, mode = 0.
- Register map (written into shadow registers on cfg_we):
  - addr 0-8: coef[k], with k = r*3+c. r=0 is the oldest row (y-2); c=0 is the oldest column (x-2).
  - addr 9: line width. Writes below 3 or above MAX_WIDTH are ignored.
  - addr 10: mode, bit 0. 0 = saturate to [0, 2^DATA_WIDTH-1]; 1 = absolute value, then saturate to 2^DATA_WIDTH-1.
  - Other addresses are ignored.
- Shadow-to-active copy:
  - Happens on the cycle a pixel with s_axis_tuser=1 is accepted; that pixel is processed with the new values.
  - A cfg write in the same cycle reaches the active set only at the next SOF.
- Handshake:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready, i.e. a single output register with full throughput.
  - Input is accepted when tvalid && tready.
  - m_axis_* are held stable while m_axis_tvalid && !m_axis_tready.
- Counters:
  - col increments on each accepted pixel and wraps to 0 at width-1; row increments at wrap.
  - An accepted tuser pixel forces col=0, row=0 and sets frame_active.
  - Pixels arriving before the first SOF after reset are dropped: accepted but produce no output.
  - A tuser pixel mid-line restarts the frame; line-buffer contents are don't-care until row 2.
- Line buffers:
  - Two buffers of depth MAX_WIDTH plus a 3x3 window register, advanced only on accepted pixels.
  - Output is produced only for accepted pixels with row>=2 and col>=2, giving (width-2) x (height-2) outputs per frame.
- Arithmetic:
  - Each product is signed, DATA_WIDTH+COEF_WIDTH+1 bits; the 9-term sum adds 4 guard bits.
  - If FRAC_BITS>0, add 1<<(FRAC_BITS-1), then arithmetic-shift right by FRAC_BITS.
  - Then apply the mode rule.
- Latency: m_axis_tvalid rises the cycle after the completing pixel is accepted (1 cycle).
- Output sideband:
  - m_axis_tlast = 1 when col == width-1.
  - m_axis_tuser = 1 when row == 2 and col == 2.
- err_line: set when s_axis_tlast on an accepted pixel disagrees with (col == width-1). Stays set until reset; data flow is unaffected.
- Reset mid-frame: pending output is discarded, and nothing is output until the next SOF.

Test Plan:
- Identity (reset defaults), width=4, 4x4 frame with pixel = 16*y+x:
  - Output is 4 pixels: 0x11, 0x12, 0x21, 0x22.
  - tlast is set on 0x12 and 0x22; tuser only on 0x11.
- Sobel-X:
  - Kernel -1,0,1 / -2,0,2 / -1,0,1, mode=1, width=8, pixel = 10*x.
  - Every output = 80; 6 outputs per line.
  - Mirrored kernel with mode=0 gives every output = 0.
- Saturation:
  - All nine coefs = 1, FRAC_BITS=0, all pixels 255 gives output 255.
  - With FRAC_BITS=2 and coef=1 (0.25), pixels 3 give 9*3=27, then (27+2)>>2 = 7.
- Backpressure: m_axis_tready toggles in a pseudo-random pattern (1,0,0,1,...). The data sequence must equal the tready=1 run, with no loss or duplication and held stable while stalled.
- Config timing: write coef4=2 mid-frame. Current-frame outputs are unchanged; outputs double starting at the next frame's first output.
- Faults:
  - s_axis_tlast on col 2 with width=4 sets err_line=1, which stays set.
  - Asserting ARESETN=0 mid-frame: m_axis_tvalid=0 immediately, no output until a new SOF, and the identity kernel is restored.
